// File: rtl/bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_arbiter_if : two-master request bus plus downstream memory bus  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface bus_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic [AW-1:0] m0_addr;
   logic          m0_rd_en;
   logic          m0_wr_en;
   logic [DW-1:0] m0_wr_data;
   logic [DW-1:0] m0_rd_data;
   logic          m0_rd_valid;
   logic          m0_wr_ack;

   logic [AW-1:0] m1_addr;
   logic          m1_rd_en;
   logic          m1_wr_en;
   logic [DW-1:0] m1_wr_data;
   logic [DW-1:0] m1_rd_data;
   logic          m1_rd_valid;
   logic          m1_wr_ack;

   logic [AW-1:0] s_addr;
   logic          s_rd_en;
   logic          s_wr_en;
   logic [DW-1:0] s_wr_data;
   logic [DW-1:0] s_rd_data;
   logic          s_rd_valid;

   logic          err;
   logic          err_clr;
   logic          busy;

   // slave: the arbiter, serving both requesters; master: requesters and memory
   modport slave (
      input  m0_addr, m0_rd_en, m0_wr_en, m0_wr_data,
      output m0_rd_data, m0_rd_valid, m0_wr_ack,
      input  m1_addr, m1_rd_en, m1_wr_en, m1_wr_data,
      output m1_rd_data, m1_rd_valid, m1_wr_ack,
      output s_addr, s_rd_en, s_wr_en, s_wr_data,
      input  s_rd_data, s_rd_valid,
      output err, busy,
      input  err_clr
   );

   modport master (
      output m0_addr, m0_rd_en, m0_wr_en, m0_wr_data,
      input  m0_rd_data, m0_rd_valid, m0_wr_ack,
      output m1_addr, m1_rd_en, m1_wr_en, m1_wr_data,
      input  m1_rd_data, m1_rd_valid, m1_wr_ack,
      input  s_addr, s_rd_en, s_wr_en, s_wr_data,
      output s_rd_data, s_rd_valid,
      input  err, busy,
      output err_clr
   );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_arbiter : round-robin two-master arbiter with read timeout      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bus_arbiter #(
   parameter int            AW       = 16,
   parameter int            DW       = 32,
   parameter int            TIMEOUT  = 15,
   parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.slave  bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR   = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

   logic [2:0]    state_q, state_d;
   logic          gnt_q, gnt_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] s_addr_q, s_addr_d;
   logic [DW-1:0] s_wr_data_q, s_wr_data_d;
   logic          s_rd_en_q, s_rd_en_d;
   logic          s_wr_en_q, s_wr_en_d;
   logic [DW-1:0] rd_data0_q, rd_data0_d;
   logic [DW-1:0] rd_data1_q, rd_data1_d;
   logic [1:0]    rd_valid_q, rd_valid_d;
   logic [1:0]    wr_ack_q, wr_ack_d;

   logic w_pend0, w_pend1, w_grant, w_take, w_timeout;

   assign w_pend0 = bus.m0_rd_en | bus.m0_wr_en;
   assign w_pend1 = bus.m1_rd_en | bus.m1_wr_en;
   assign w_grant = (w_pend0 & w_pend1) ? ~gnt_q : w_pend1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b1;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         s_addr_q    <= '0;
         s_wr_data_q <= '0;
         s_rd_en_q   <= 1'b0;
         s_wr_en_q   <= 1'b0;
         rd_data0_q  <= '0;
         rd_data1_q  <= '0;
         rd_valid_q  <= '0;
         wr_ack_q    <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         s_addr_q    <= s_addr_d;
         s_wr_data_q <= s_wr_data_d;
         s_rd_en_q   <= s_rd_en_d;
         s_wr_en_q   <= s_wr_en_d;
         rd_data0_q  <= rd_data0_d;
         rd_data1_q  <= rd_data1_d;
         rd_valid_q  <= rd_valid_d;
         wr_ack_q    <= wr_ack_d;
      end
   end

   // cnt_q counts WAIT cycles already spent, so a read accepts s_rd_valid
   // for TIMEOUT+1 cycles after the s_rd_en strobe.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      w_take    = 1'b0;
      w_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_pend0 | w_pend1) begin
               gnt_d   = w_grant;
               state_d = (w_grant ? bus.m1_wr_en : bus.m0_wr_en) ? WR : RD;
            end
         end
         WR: state_d = IDLE;
         RD: begin
            cnt_d = '0;
            if (bus.s_rd_valid) begin
               w_take  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.s_rd_valid) begin
               w_take  = 1'b1;
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               w_timeout = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_addr_d    = s_addr_q;
      s_wr_data_d = s_wr_data_q;
      rd_data0_d  = rd_data0_q;
      rd_data1_d  = rd_data1_q;
      if (state_q == IDLE && state_d != IDLE) begin
         s_addr_d    = w_grant ? bus.m1_addr : bus.m0_addr;
         s_wr_data_d = w_grant ? bus.m1_wr_data : bus.m0_wr_data;
      end
      if (w_take | w_timeout) begin
         if (gnt_q) rd_data1_d = w_take ? bus.s_rd_data : ERR_DATA;
         else       rd_data0_d = w_take ? bus.s_rd_data : ERR_DATA;
      end
      s_wr_en_d  = (state_d == WR);
      s_rd_en_d  = (state_d == RD);
      busy_d     = (state_d != IDLE);
      wr_ack_d   = (state_d == WR)   ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
      rd_valid_d = (state_d == DONE) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
      // A timeout in the same cycle as err_clr keeps the flag set.
      err_d      = w_timeout | (err_q & ~bus.err_clr);
   end

   assign bus.s_addr      = s_addr_q;
   assign bus.s_wr_data   = s_wr_data_q;
   assign bus.s_rd_en     = s_rd_en_q;
   assign bus.s_wr_en     = s_wr_en_q;
   assign bus.m0_rd_data  = rd_data0_q;
   assign bus.m1_rd_data  = rd_data1_q;
   assign bus.m0_rd_valid = rd_valid_q[0];
   assign bus.m1_rd_valid = rd_valid_q[1];
   assign bus.m0_wr_ack   = wr_ack_q[0];
   assign bus.m1_wr_ack   = wr_ack_q[1];
   assign bus.err         = err_q;
   assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bus_arbiter : directed and randomized checks of bus_arbiter      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_bus_arbiter;
   localparam int          AW       = 16;
   localparam int          DW       = 32;
   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: transaction-level view of the arbiter
   int          last_g;
   logic [31:0] exp_rd [2];
   bit          exp_err;

   bit          act [2];
   bit          isw [2];
   bit          rdx [2];
   logic [15:0] addr [2];
   logic [31:0] wd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      bus.m0_addr    = addr[0];
      bus.m0_wr_data = wd[0];
      bus.m0_wr_en   = act[0] & isw[0];
      bus.m0_rd_en   = act[0] & (~isw[0] | rdx[0]);
      bus.m1_addr    = addr[1];
      bus.m1_wr_data = wd[1];
      bus.m1_wr_en   = act[1] & isw[1];
      bus.m1_rd_en   = act[1] & (~isw[1] | rdx[1]);
   endtask

   task automatic model_reset();
      last_g    = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_err   = 1'b0;
      act[0]    = 1'b0;
      act[1]    = 1'b0;
   endtask

   function automatic logic [31:0] pulses();
      return {28'd0, bus.m1_rd_valid, bus.m0_rd_valid, bus.m1_wr_ack, bus.m0_wr_ack};
   endfunction

   // One transaction: winner picked by the round-robin rule, write acked on
   // the cycle after the sample, read answered by a slave with latency lat.
   task automatic run_txn(input int lat, input logic [31:0] rdata);
      int w;
      int done_j;
      logic [31:0] val;
      drive_reqs();
      w = (act[0] && act[1]) ? 1 - last_g : (act[1] ? 1 : 0);
      last_g = w;
      step();
      chk("busy_start", bus.busy, 1);
      chk("s_addr", bus.s_addr, addr[w]);
      if (isw[w]) begin
         chk("s_wr_en", bus.s_wr_en, 1);
         chk("s_rd_en_in_wr", bus.s_rd_en, 0);
         chk("s_wr_data", bus.s_wr_data, wd[w]);
         chk("wr_ack", pulses(), 32'(1 << w));
      end else begin
         chk("s_rd_en", bus.s_rd_en, 1);
         chk("no_pulse_rd", pulses(), 0);
         done_j = (lat <= TIMEOUT + 1) ? lat + 1 : TIMEOUT + 2;
         val    = (lat <= TIMEOUT + 1) ? rdata : ERR_DATA;
         for (int j = 0; j <= done_j; j++) begin
            if (j > 0) begin
               step();
               chk("s_rd_en_once", bus.s_rd_en, 0);
               if (j == done_j) begin
                  if (lat > TIMEOUT + 1) exp_err = 1'b1;
                  exp_rd[w] = val;
                  chk("rd_valid", pulses(), 32'(4 << w));
                  chk("m0_rd_data", bus.m0_rd_data, exp_rd[0]);
                  chk("m1_rd_data", bus.m1_rd_data, exp_rd[1]);
               end else begin
                  chk("wait_quiet", pulses(), 0);
                  chk("busy_wait", bus.busy, 1);
               end
               chk("err", bus.err, exp_err);
            end
            bus.s_rd_valid = (j == lat);
            bus.s_rd_data  = (j == lat) ? rdata : $urandom;
         end
      end
      act[w] = 1'b0;
   endtask

   // Completion cycle returns to IDLE; requests set now are sampled one edge later.
   task automatic gap(input bit clr);
      drive_reqs();
      bus.err_clr = clr;
      step();
      bus.s_rd_valid = 1'b0;
      bus.err_clr    = 1'b0;
      if (clr) exp_err = 1'b0;
      chk("gap_busy", bus.busy, 0);
      chk("gap_quiet", pulses(), 0);
      chk("gap_err", bus.err, exp_err);
   endtask

   task automatic arm(input int m);
      act[m]  = 1'b1;
      isw[m]  = 1'($urandom_range(0, 1));
      rdx[m]  = 1'($urandom_range(0, 1));
      addr[m] = 16'($urandom);
      wd[m]   = $urandom;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      for (int m = 0; m < 2; m++) begin
         isw[m] = 1'b0; rdx[m] = 1'b0; addr[m] = '0; wd[m] = '0;
      end
      drive_reqs();
      bus.s_rd_valid = 1'b0;
      bus.s_rd_data  = '0;
      bus.err_clr    = 1'b0;

      // Reset values
      step();
      step();
      chk("rst_s_addr", bus.s_addr, 0);
      chk("rst_s_wr_data", bus.s_wr_data, 0);
      chk("rst_strobes", {bus.s_rd_en, bus.s_wr_en}, 0);
      chk("rst_pulses", pulses(), 0);
      chk("rst_err_busy", {bus.err, bus.busy}, 0);
      chk("rst_rd_data", bus.m0_rd_data | bus.m1_rd_data, 0);
      rst = 1'b0;

      // Single write from m0
      act[0] = 1'b1; isw[0] = 1'b1; rdx[0] = 1'b0; addr[0] = 16'h4000; wd[0] = 32'h5;
      run_txn(0, '0);
      gap(1'b0);

      // Read from m1, slave answers the cycle after s_rd_en
      act[1] = 1'b1; isw[1] = 1'b0; addr[1] = 16'h8004;
      run_txn(1, 32'h12345678);
      gap(1'b0);

      // Contention from reset: both masters hold write requests continuously
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      act[0] = 1'b1; isw[0] = 1'b1; rdx[0] = 1'b0; addr[0] = 16'h0100; wd[0] = 32'hA0;
      act[1] = 1'b1; isw[1] = 1'b1; rdx[1] = 1'b0; addr[1] = 16'h0200; wd[1] = 32'hB1;
      drive_reqs();
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c % 2 == 1) begin
            chk("contend_ack", pulses(), (((c - 1) / 2) % 2 == 0) ? 32'h1 : 32'h2);
            chk("contend_data", bus.s_wr_data, (((c - 1) / 2) % 2 == 0) ? 32'hA0 : 32'hB1);
         end else begin
            chk("contend_gap", pulses(), 0);
         end
      end
      act[0] = 1'b0;
      act[1] = 1'b0;
      last_g = 1;
      gap(1'b0);

      // Timeout: nobody answers m0's read
      act[0] = 1'b1; isw[0] = 1'b0; addr[0] = 16'h2000;
      run_txn(1000, '0);
      gap(1'b0);
      chk("err_sticky", bus.err, 1);
      gap(1'b1);

      // Reset while waiting, then a late slave answer
      act[0] = 1'b1; isw[0] = 1'b0; addr[0] = 16'h3000;
      drive_reqs();
      step();
      chk("rstwait_rd_en", bus.s_rd_en, 1);
      step();
      step();
      rst = 1'b1;
      act[0] = 1'b0;
      drive_reqs();
      step();
      rst = 1'b0;
      model_reset();
      bus.s_rd_valid = 1'b1;
      bus.s_rd_data  = 32'hCAFEF00D;
      step();
      bus.s_rd_valid = 1'b0;
      chk("rstwait_quiet", pulses(), 0);
      chk("rstwait_busy_err", {bus.busy, bus.err}, 0);
      chk("rstwait_rd_data", bus.m0_rd_data, 0);
      step();
      chk("rstwait_quiet2", pulses(), 0);
      chk("rstwait_idle", bus.busy, 0);

      // Stale valid in IDLE, then a normal read
      bus.s_rd_valid = 1'b1;
      bus.s_rd_data  = 32'h0BADBAD0;
      step();
      bus.s_rd_valid = 1'b0;
      chk("stale_quiet", pulses(), 0);
      chk("stale_busy", bus.busy, 0);
      act[0] = 1'b1; isw[0] = 1'b0; addr[0] = 16'h0010;
      run_txn(3, 32'h600DDA7A);
      gap(1'b0);

      // Randomized traffic; the loser keeps its request across transactions
      for (int n = 0; n < 60; n++) begin
         for (int m = 0; m < 2; m++)
            if (!act[m] && $urandom_range(0, 3) != 0) arm(m);
         if (!act[0] && !act[1]) arm(int'($urandom_range(0, 1)));
         run_txn(int'($urandom_range(0, TIMEOUT + 2)), $urandom);
         gap($urandom_range(0, 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
